spi_slave_stream: RTL and testbench



---
 rtl/spi_slave_stream_pkg.sv | 23 ++
 rtl/spi_slave_stream_if.sv | 44 ++++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave_stream.sv | 160 ++++++++++++++++
 tb/tb_spi_slave_stream.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_stream_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_pkg : shared constants and helpers for spi_slave_stream      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package spi_pkg;

  // SPI mode encoding {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int unsigned SCK_SYNC  = 3;
  localparam int unsigned SSEL_SYNC = 3;
  localparam int unsigned MOSI_SYNC = 2;

  function automatic int unsigned bitcnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_stream_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_slave_stream_if : SPI pins plus TX/RX stream and status      |
// | MISO_TRISTATE_EN adds MISO_oe. Revision: 1.0                     |
// +------------------------------------------------------------------+
interface spi_slave_stream_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             SCK;
  logic             SSEL;
  logic             MOSI;
  logic             MISO;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             msg_start;
  logic             msg_end;
  logic [CNT_W-1:0] word_cnt;
  logic             underrun;
`ifdef MISO_TRISTATE_EN
  logic             MISO_oe;
`endif

  modport slave (
    input  SCK, SSEL, MOSI, tx_data, tx_valid,
    output MISO, tx_ready, rx_data, rx_valid, msg_start, msg_end, word_cnt, underrun
`ifdef MISO_TRISTATE_EN
    , output MISO_oe
`endif
  );

  modport master (
    output SCK, SSEL, MOSI, tx_data, tx_valid,
    input  MISO, tx_ready, rx_data, rx_valid, msg_start, msg_end, word_cnt, underrun
`ifdef MISO_TRISTATE_EN
    , input MISO_oe
`endif
  );

endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_sync_edge : N-stage synchroniser with rise/fall strobes      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module spi_sync_edge #(
  parameter int unsigned DEPTH   = 3,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  // Level is always stage 1; edges compare stage 1 against the oldest stage
  assign lvl_o  = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[DEPTH-1];
  assign fall_o = ~sync_q[1] & sync_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_slave_stream : parametrised SPI slave with TX/RX streams     |
// | Optional macro MISO_TRISTATE_EN. Revision: 1.0                   |
// +------------------------------------------------------------------+
module spi_slave_stream
  import spi_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter bit               CPOL  = 1'b0,
  parameter bit               CPHA  = 1'b0,
  parameter logic [WIDTH-1:0] FILL  = '0,
  parameter int unsigned      CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  spi_slave_stream_if.slave bus
);

  localparam int unsigned    BW             = bitcnt_w(WIDTH);
  localparam logic [BW-1:0]  LAST           = BW'(WIDTH - 1);
  localparam logic [1:0]     MODE           = {CPOL, CPHA};
  localparam bit             SAMPLE_ON_LEAD = (MODE == MODE0) || (MODE == MODE2);

  logic unused_sck_lvl, sck_rise, sck_fall;
  logic ssel_lvl, ssel_rise, ssel_fall;
  logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.DEPTH(SCK_SYNC), .RST_VAL(CPOL)) u_sync_sck (
    .clk(clk), .rst(rst), .d_i(bus.SCK),
    .lvl_o(unused_sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.DEPTH(SSEL_SYNC), .RST_VAL(1'b1)) u_sync_ssel (
    .clk(clk), .rst(rst), .d_i(bus.SSEL),
    .lvl_o(ssel_lvl), .rise_o(ssel_rise), .fall_o(ssel_fall)
  );
  spi_sync_edge #(.DEPTH(MOSI_SYNC), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(bus.MOSI),
    .lvl_o(mosi_lvl), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = SAMPLE_ON_LEAD ? lead_edge : trail_edge;
  assign shift_edge  = SAMPLE_ON_LEAD ? trail_edge : lead_edge;

  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, rx_data_q, rx_data_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             underrun_q, underrun_d, rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic             msg_start_q, msg_start_d, msg_end_q, msg_end_d;
  logic [1:0]       settle_q, settle_d;
  logic             armed_q, armed_d;

  // A select held low across reset must not start a message: arm only after
  // SSEL has been seen high once the synchroniser has flushed.
  logic start, active;
  assign start  = armed_q & ssel_fall;
  assign active = armed_q & ~ssel_lvl;

  logic [WIDTH-1:0] rx_word, load_word;
  assign rx_word   = {rx_sr_q[WIDTH-2:0], mosi_lvl};
  assign load_word = bus.tx_valid ? bus.tx_data : FILL;

  always_comb begin
    bitcnt_d    = bitcnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    rx_data_d   = rx_data_q;
    word_cnt_d  = word_cnt_q;
    underrun_d  = underrun_q;
    rx_valid_d  = 1'b0;
    tx_ready_d  = 1'b0;
    msg_start_d = 1'b0;
    msg_end_d   = ssel_rise;
    settle_d    = {settle_q[0], 1'b1};
    armed_d     = armed_q | (settle_q[1] & ssel_lvl);

    if (start) begin
      msg_start_d = 1'b1;
      bitcnt_d    = '0;
      word_cnt_d  = '0;
      underrun_d  = 1'b0;
      if (!CPHA) begin
        tx_sr_d    = load_word;
        tx_ready_d = bus.tx_valid;
        underrun_d = ~bus.tx_valid;
      end
    end else if (!active) begin
      bitcnt_d = '0;
    end else if (sample_edge) begin
      rx_sr_d = rx_word;
      if (bitcnt_q == LAST) begin
        bitcnt_d   = '0;
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
        if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_W'(1);
      end else begin
        bitcnt_d = bitcnt_q + BW'(1);
      end
    end else if (shift_edge) begin
      // CPHA=0 never sees a shift edge at bit 0 before the first sample,
      // so the word loaded at msg_start is not reloaded here.
      if (bitcnt_q == '0) begin
        tx_sr_d    = load_word;
        tx_ready_d = bus.tx_valid;
        if (!bus.tx_valid) underrun_d = 1'b1;
      end else begin
        tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q    <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      rx_data_q   <= '0;
      word_cnt_q  <= '0;
      underrun_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      msg_start_q <= 1'b0;
      msg_end_q   <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      bitcnt_q    <= bitcnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      rx_data_q   <= rx_data_d;
      word_cnt_q  <= word_cnt_d;
      underrun_q  <= underrun_d;
      rx_valid_q  <= rx_valid_d;
      tx_ready_q  <= tx_ready_d;
      msg_start_q <= msg_start_d;
      msg_end_q   <= msg_end_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
    end
  end

`ifdef MISO_TRISTATE_EN
  assign bus.MISO    = active ? tx_sr_q[WIDTH-1] : 1'bz;
  assign bus.MISO_oe = active;
`else
  assign bus.MISO    = tx_sr_q[WIDTH-1];
`endif
  assign bus.tx_ready  = tx_ready_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.msg_start = msg_start_q;
  assign bus.msg_end   = msg_end_q;
  assign bus.word_cnt  = word_cnt_q;
  assign bus.underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_stream.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_spi_slave_stream : scoreboard bench, mode 0/8-bit and 3/16-bit|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_spi_slave_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_stream_if #(.WIDTH(8),  .CNT_W(8)) b0 ();
  spi_slave_stream_if #(.WIDTH(16), .CNT_W(8)) b3 ();

  spi_slave_stream #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .FILL(8'hFF), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );
  spi_slave_stream #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .FILL(16'h0000), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard queues and TX producer queues
  logic [7:0]  exp0[$];
  logic [15:0] exp3[$];
  logic [7:0]  txq0[$];
  logic [15:0] txq3[$];
  logic        tx_en0 = 1'b0, tx_en3 = 1'b0;
  int          rdy0 = 0, rdy3 = 0, ms0 = 0, me0 = 0;

  always @(negedge clk) begin
    if (b0.tx_ready === 1'b1 && txq0.size() != 0) begin void'(txq0.pop_front()); rdy0++; end
    if (b3.tx_ready === 1'b1 && txq3.size() != 0) begin void'(txq3.pop_front()); rdy3++; end
    b0.tx_valid = tx_en0 && (txq0.size() != 0);
    b0.tx_data  = (txq0.size() != 0) ? txq0[0] : 8'h00;
    b3.tx_valid = tx_en3 && (txq3.size() != 0);
    b3.tx_data  = (txq3.size() != 0) ? txq3[0] : 16'h0000;
  end

  // Monitor: pops the expected word whenever a DUT presents rx_valid
  always @(negedge clk) begin
    if (b0.rx_valid === 1'b1) begin
      if (exp0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx0_unexpected: got %h expected no word", b0.rx_data);
      end else check("rx0_data", 32'(b0.rx_data), 32'(exp0.pop_front()));
    end
    if (b3.rx_valid === 1'b1) begin
      if (exp3.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx3_unexpected: got %h expected no word", b3.rx_data);
      end else check("rx3_data", 32'(b3.rx_data), 32'(exp3.pop_front()));
    end
    if (b0.msg_start === 1'b1) ms0++;
    if (b0.msg_end === 1'b1) me0++;
  end

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic set_sck(input int w, input logic v);
    if (w == 0) b0.SCK = v; else b3.SCK = v;
  endtask
  task automatic set_ssel(input int w, input logic v);
    if (w == 0) b0.SSEL = v; else b3.SSEL = v;
  endtask
  task automatic set_mosi(input int w, input logic v);
    if (w == 0) b0.MOSI = v; else b3.MOSI = v;
  endtask
  function automatic logic get_miso(input int w);
    return (w == 0) ? b0.MISO : b3.MISO;
  endfunction

  // Master: clocks nbits MSB first; deselects before SCK returns to idle
  task automatic xfer(input int w, input int nbits, input logic [31:0] mo, output logic [31:0] mi);
    logic cpol, cpha;
    cpol = (w != 0);
    cpha = (w != 0);
    mi = '0;
    @(negedge clk);
    set_ssel(w, 1'b0);
    if (!cpha) set_mosi(w, mo[nbits-1]);
    half();
    for (int k = 0; k < nbits; k++) begin
      if (!cpha) begin
        mi = {mi[30:0], get_miso(w)};
        set_sck(w, ~cpol);
        half();
        if (k != nbits - 1) begin
          set_sck(w, cpol);
          set_mosi(w, mo[nbits-2-k]);
          half();
        end
      end else begin
        set_sck(w, ~cpol);
        set_mosi(w, mo[nbits-1-k]);
        half();
        mi = {mi[30:0], get_miso(w)};
        set_sck(w, cpol);
        half();
      end
    end
    set_ssel(w, 1'b1);
    half();
    set_sck(w, cpol);
    half();
    half();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] mi;
    int          ms_snap;
    b0.SSEL = 1'b1; b0.SCK = 1'b0; b0.MOSI = 1'b0;
    b3.SSEL = 1'b1; b3.SCK = 1'b1; b3.MOSI = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
`ifdef MISO_TRISTATE_EN
    check("miso_z_idle", {31'b0, b0.MISO === 1'bz}, 32'd1);
    check("miso_oe_idle", {31'b0, b0.MISO_oe}, 32'd0);
`else
    check("miso_rst", {31'b0, b0.MISO}, 32'd0);
`endif
    check("rx_data_rst", 32'(b0.rx_data), 32'h0);
    check("word_cnt_rst", 32'(b0.word_cnt), 32'h0);
    check("underrun_rst", {31'b0, b0.underrun}, 32'd0);
    check("strobes_rst", {28'b0, b0.rx_valid, b0.tx_ready, b0.msg_start, b0.msg_end}, 32'h0);

    // Mode 0: two words
    txq0.push_back(8'h01); txq0.push_back(8'h02); tx_en0 = 1'b1;
    exp0.push_back(8'hA5); exp0.push_back(8'h3C);
    xfer(0, 16, 32'h0000A53C, mi);
    check("m0_miso", mi, 32'h00000102);
    check("m0_word_cnt", 32'(b0.word_cnt), 32'd2);
    check("m0_tx_ready_cnt", rdy0, 32'd2);
    check("m0_msg_start_cnt", ms0, 32'd1);
    check("m0_msg_end_cnt", me0, 32'd1);
    check("m0_underrun", {31'b0, b0.underrun}, 32'd0);

    // Underrun with tx_valid low
    tx_en0 = 1'b0;
    exp0.push_back(8'h5A);
    xfer(0, 8, 32'h5A, mi);
    check("ur_miso_fill", mi, 32'h000000FF);
    check("ur_flag_set", {31'b0, b0.underrun}, 32'd1);
    check("ur_word_cnt", 32'(b0.word_cnt), 32'd1);
    txq0.push_back(8'h81); tx_en0 = 1'b1;
    half();
    check("ur_flag_held", {31'b0, b0.underrun}, 32'd1);
    exp0.push_back(8'hE7);
    xfer(0, 8, 32'hE7, mi);
    check("ur_next_miso", mi, 32'h00000081);
    check("ur_flag_cleared", {31'b0, b0.underrun}, 32'd0);

    // Abort after 5 bits, then a clean message
    txq0.push_back(8'h77);
    xfer(0, 5, 32'h16, mi);
    check("ab_miso", mi, 32'h0000000E);
    check("ab_word_cnt", 32'(b0.word_cnt), 32'd0);
    check("ab_msg_end_cnt", me0, 32'd4);
    txq0.push_back(8'h42);
    exp0.push_back(8'hC3);
    xfer(0, 8, 32'hC3, mi);
    check("ab_next_miso", mi, 32'h00000042);
    check("ab_next_word_cnt", 32'(b0.word_cnt), 32'd1);

    // Mode 3, 16-bit
    txq3.push_back(16'h1234); tx_en3 = 1'b1;
    exp3.push_back(16'hBEEF);
    xfer(3, 16, 32'h0000BEEF, mi);
    check("m3_miso", mi, 32'h00001234);
    check("m3_word_cnt", 32'(b3.word_cnt), 32'd1);
    check("m3_tx_ready_cnt", rdy3, 32'd1);

    // Reset while SSEL is low mid-word
    txq0.push_back(8'h99);
    @(negedge clk);
    b0.SSEL = 1'b0; b0.MOSI = 1'b1;
    half();
    repeat (3) begin b0.SCK = 1'b1; half(); b0.SCK = 1'b0; half(); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`ifndef MISO_TRISTATE_EN
    check("rr_miso", {31'b0, b0.MISO}, 32'd0);
`endif
    check("rr_rx_data", 32'(b0.rx_data), 32'h0);
    check("rr_word_cnt", 32'(b0.word_cnt), 32'h0);
    check("rr_rx3_data", 32'(b3.rx_data), 32'h0);
    ms_snap = ms0;
    repeat (8) begin b0.SCK = 1'b1; half(); b0.SCK = 1'b0; half(); end
    check("rr_no_msg_start", ms0, ms_snap);
    check("rr_no_words", 32'(b0.word_cnt), 32'h0);
    b0.SSEL = 1'b1;
    half(); half();
    txq0.delete();
    txq0.push_back(8'h35);
    exp0.push_back(8'h6B);
    xfer(0, 8, 32'h6B, mi);
    check("rr_next_miso", mi, 32'h00000035);
    check("rr_next_word_cnt", 32'(b0.word_cnt), 32'd1);
    check("rr_msg_start_once", ms0, ms_snap + 1);

    half();
    check("rx0_pending", exp0.size(), 32'd0);
    check("rx3_pending", exp3.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
